// File: rtl/spu_dual_issue_router.sv
// Issue stage after the SPU decoder: buffers decoded pairs and routes each slot
// to the even or odd pipe, dual-issuing when the pair is independent.
module spu_dual_issue_router #(
  parameter int INSTR_W    = 32,
  parameter int REG_AW     = 7,
  parameter int PAIR_DEPTH = 4,
  parameter int DUAL_EN    = 1,
  parameter int CNT_W      = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [INSTR_W-1:0]  in_instr1,
  input  logic [INSTR_W-1:0]  in_instr2,
  input  logic                in_v1,
  input  logic                in_v2,
  input  logic                in_even1,
  input  logic                in_even2,
  input  logic [REG_AW-1:0]   in_dst1,
  input  logic [REG_AW-1:0]   in_dst2,
  input  logic                in_dst_en1,
  input  logic                in_dst_en2,
  input  logic [3*REG_AW-1:0] in_src2,
  input  logic [2:0]          in_src_en2,
  output logic                even_valid,
  output logic                odd_valid,
  input  logic                even_ready,
  input  logic                odd_ready,
  output logic [INSTR_W-1:0]  even_instr,
  output logic [INSTR_W-1:0]  odd_instr,
  output logic                even_slot,
  output logic                odd_slot,
  output logic [CNT_W-1:0]    dual_cnt,
  output logic [CNT_W-1:0]    split_cnt
);

  localparam int PW = $clog2(PAIR_DEPTH);

  typedef struct packed {
    logic [INSTR_W-1:0]  instr1;
    logic [INSTR_W-1:0]  instr2;
    logic                v1;
    logic                v2;
    logic                even1;
    logic                even2;
    logic [REG_AW-1:0]   dst1;
    logic [REG_AW-1:0]   dst2;
    logic                dst_en1;
    logic                dst_en2;
    logic [3*REG_AW-1:0] src2;
    logic [2:0]          src_en2;
  } pair_t;

  pair_t         mem [PAIR_DEPTH];
  pair_t         in_pair;
  pair_t         head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;

  // done bits mark slots of the head pair already issued; cleared on pop
  logic done1;
  logic done2;

  logic head_valid;
  logic push;
  logic pop;
  logic pend1;
  logic pend2;
  logic free_even;
  logic free_odd;
  logic issue1;
  logic issue2;
  logic raw;
  logic waw;
  logic pair_ok;
  logic load_even;
  logic load_odd;

  always_comb begin
    in_pair.instr1  = in_instr1;
    in_pair.instr2  = in_instr2;
    in_pair.v1      = in_v1;
    in_pair.v2      = in_v2;
    in_pair.even1   = in_even1;
    in_pair.even2   = in_even2;
    in_pair.dst1    = in_dst1;
    in_pair.dst2    = in_dst2;
    in_pair.dst_en1 = in_dst_en1;
    in_pair.dst_en2 = in_dst_en2;
    in_pair.src2    = in_src2;
    in_pair.src_en2 = in_src_en2;
  end

  assign in_ready   = (count != (PW+1)'(PAIR_DEPTH));
  assign push       = in_valid && in_ready;
  assign head_valid = (count != '0);
  assign head       = mem[rd_ptr];

  assign pend1     = head_valid && head.v1 && !done1;
  assign pend2     = head_valid && head.v2 && !done2;
  assign free_even = !even_valid || even_ready;
  assign free_odd  = !odd_valid  || odd_ready;

  // NOTE: combinational blocks assign a default first so no path can infer a latch.
  always_comb begin
    raw = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (head.src_en2[i] && head.dst_en1 &&
          head.src2[(3-i)*REG_AW-1 -: REG_AW] == head.dst1)
        raw = 1'b1;
    end
  end

  assign waw     = head.dst_en1 && head.dst_en2 && (head.dst1 == head.dst2);
  assign pair_ok = (DUAL_EN != 0) && (head.even1 != head.even2) && !raw && !waw;

  assign issue1 = pend1 && (head.even1 ? free_even : free_odd);
  assign issue2 = pend2 && (head.even2 ? free_even : free_odd) &&
                  (!pend1 || (issue1 && pair_ok));

  assign pop = head_valid && !(pend1 && !issue1) && !(pend2 && !issue2);

  assign load_even = (issue1 && head.even1) || (issue2 && head.even2);
  assign load_odd  = (issue1 && !head.even1) || (issue2 && !head.even2);

  // NOTE: pair storage has no reset; validity is tracked by count/pointers only.
  always_ff @(posedge clk) begin
    if (push && !flush)
      mem[wr_ptr] <= in_pair;
  end

  // NOTE: all state registers use non-blocking assignments so every update sees pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      done1      <= 1'b0;
      done2      <= 1'b0;
      even_valid <= 1'b0;
      odd_valid  <= 1'b0;
      even_instr <= '0;
      odd_instr  <= '0;
      even_slot  <= 1'b0;
      odd_slot   <= 1'b0;
      dual_cnt   <= '0;
      split_cnt  <= '0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      done1      <= 1'b0;
      done2      <= 1'b0;
      even_valid <= 1'b0;
      odd_valid  <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;

      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        done1  <= 1'b0;
        done2  <= 1'b0;
      end else begin
        if (issue1) done1 <= 1'b1;
        if (issue2) done2 <= 1'b1;
      end

      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;

      if (load_even) begin
        even_valid <= 1'b1;
        even_instr <= (issue1 && head.even1) ? head.instr1 : head.instr2;
        even_slot  <= !(issue1 && head.even1);
      end else if (even_ready) begin
        even_valid <= 1'b0;
      end

      if (load_odd) begin
        odd_valid <= 1'b1;
        odd_instr <= (issue1 && !head.even1) ? head.instr1 : head.instr2;
        odd_slot  <= !(issue1 && !head.even1);
      end else if (odd_ready) begin
        odd_valid <= 1'b0;
      end

      // slot2 issuing after slot1 was already gone means the pair was split
      if (issue1 && issue2 && (dual_cnt != '1))
        dual_cnt <= dual_cnt + 1'b1;
      if (issue2 && !pend1 && head.v1 && (split_cnt != '1))
        split_cnt <= split_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_spu_dual_issue_router.sv
// Scoreboard bench for spu_dual_issue_router: directed pairs, expected words
// queued per pipe and checked by a monitor on each accepted output.
module tb_spu_dual_issue_router;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr1, in_instr2;
  logic        in_v1, in_v2, in_even1, in_even2;
  logic [6:0]  in_dst1, in_dst2;
  logic        in_dst_en1, in_dst_en2;
  logic [20:0] in_src2;
  logic [2:0]  in_src_en2;
  logic        even_valid, odd_valid, even_ready, odd_ready;
  logic [31:0] even_instr, odd_instr;
  logic        even_slot, odd_slot;
  logic [15:0] dual_cnt, split_cnt;

  logic        d0_flush, d0_in_valid, d0_in_ready;
  logic        d0_even_valid, d0_odd_valid, d0_even_ready, d0_odd_ready;
  logic [31:0] d0_even_instr, d0_odd_instr;
  logic        d0_even_slot, d0_odd_slot;
  logic [15:0] d0_dual_cnt, d0_split_cnt;

  int checks   = 0;
  int failures = 0;

  logic [32:0] exp_even[$];
  logic [32:0] exp_odd[$];

  spu_dual_issue_router #(.DUAL_EN(1)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr1(in_instr1), .in_instr2(in_instr2),
    .in_v1(in_v1), .in_v2(in_v2), .in_even1(in_even1), .in_even2(in_even2),
    .in_dst1(in_dst1), .in_dst2(in_dst2),
    .in_dst_en1(in_dst_en1), .in_dst_en2(in_dst_en2),
    .in_src2(in_src2), .in_src_en2(in_src_en2),
    .even_valid(even_valid), .odd_valid(odd_valid),
    .even_ready(even_ready), .odd_ready(odd_ready),
    .even_instr(even_instr), .odd_instr(odd_instr),
    .even_slot(even_slot), .odd_slot(odd_slot),
    .dual_cnt(dual_cnt), .split_cnt(split_cnt)
  );

  spu_dual_issue_router #(.DUAL_EN(0)) dut0 (
    .clk(clk), .reset(reset), .flush(d0_flush),
    .in_valid(d0_in_valid), .in_ready(d0_in_ready),
    .in_instr1(in_instr1), .in_instr2(in_instr2),
    .in_v1(in_v1), .in_v2(in_v2), .in_even1(in_even1), .in_even2(in_even2),
    .in_dst1(in_dst1), .in_dst2(in_dst2),
    .in_dst_en1(in_dst_en1), .in_dst_en2(in_dst_en2),
    .in_src2(in_src2), .in_src_en2(in_src_en2),
    .even_valid(d0_even_valid), .odd_valid(d0_odd_valid),
    .even_ready(d0_even_ready), .odd_ready(d0_odd_ready),
    .even_instr(d0_even_instr), .odd_instr(d0_odd_instr),
    .even_slot(d0_even_slot), .odd_slot(d0_odd_slot),
    .dual_cnt(d0_dual_cnt), .split_cnt(d0_split_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the expected word on every accepted transfer and checks
  // that a stalled output holds its value.
  logic        hold_e, hold_o;
  logic [32:0] prev_e, prev_o;
  initial begin
    hold_e = 1'b0;
    hold_o = 1'b0;
  end

  always @(negedge clk) begin
    if (reset) begin
      if (hold_e) check("even_hold", {even_valid, even_slot, even_instr}, {1'b1, prev_e});
      if (hold_o) check("odd_hold", {odd_valid, odd_slot, odd_instr}, {1'b1, prev_o});
      if (even_valid && even_ready) begin
        if (exp_even.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL even_unexpected actual=%0h expected=none", even_instr);
        end else begin
          check("even_word", {even_slot, even_instr}, exp_even.pop_front());
        end
      end
      if (odd_valid && odd_ready) begin
        if (exp_odd.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL odd_unexpected actual=%0h expected=none", odd_instr);
        end else begin
          check("odd_word", {odd_slot, odd_instr}, exp_odd.pop_front());
        end
      end
      hold_e = even_valid && !even_ready && !flush;
      hold_o = odd_valid && !odd_ready && !flush;
      prev_e = {even_slot, even_instr};
      prev_o = {odd_slot, odd_instr};
    end else begin
      hold_e = 1'b0;
      hold_o = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input logic [31:0] i1, i2, input logic v1, v2, e1, e2,
                            input logic [6:0] d1, d2, input logic de1, de2,
                            input logic [20:0] s2, input logic [2:0] se2);
    in_instr1 = i1;  in_instr2 = i2;
    in_v1 = v1;      in_v2 = v2;
    in_even1 = e1;   in_even2 = e2;
    in_dst1 = d1;    in_dst2 = d2;
    in_dst_en1 = de1; in_dst_en2 = de2;
    in_src2 = s2;    in_src_en2 = se2;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic push(input logic [31:0] i1, i2, input logic v1, v2, e1, e2,
                      input logic [6:0] d1, d2, input logic de1, de2,
                      input logic [20:0] s2, input logic [2:0] se2);
    logic ok;
    set_fields(i1, i2, v1, v2, e1, e2, d1, d2, de1, de2, s2, se2);
    if (v1) begin
      if (e1) exp_even.push_back({1'b0, i1});
      else    exp_odd.push_back({1'b0, i1});
    end
    if (v2) begin
      if (e2) exp_even.push_back({1'b1, i2});
      else    exp_odd.push_back({1'b1, i2});
    end
    in_valid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      if (ok) break;
    end
    if (!ok) check("push_timeout", 64'd0, 64'd1);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 60; n++) begin
      if (exp_even.size() == 0 && exp_odd.size() == 0 && !even_valid && !odd_valid) break;
      step();
    end
    check("drain_even_left", 64'(exp_even.size()), 64'd0);
    check("drain_odd_left", 64'(exp_odd.size()), 64'd0);
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    d0_in_valid = 1'b0;
    d0_flush = 1'b0;
    even_ready = 1'b1;
    odd_ready = 1'b1;
    d0_even_ready = 1'b1;
    d0_odd_ready = 1'b1;
    set_fields(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 7'd0, 1'b0, 1'b0, 21'd0, 3'b000);

    #2 reset = 1'b0;
    #1;
    check("rst_even_valid", even_valid, 0);
    check("rst_odd_valid", odd_valid, 0);
    check("rst_even_instr", even_instr, 0);
    check("rst_odd_slot", odd_slot, 0);
    check("rst_dual_cnt", dual_cnt, 0);
    check("rst_split_cnt", split_cnt, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_d0_in_ready", d0_in_ready, 1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    step();

    // even add + odd load, independent: dual issue one edge after the push
    push(32'hA000_0001, 32'hB000_0001, 1, 1, 1, 0, 7'd3, 7'd4, 1, 1,
         {7'd10, 7'd11, 7'd12}, 3'b111);
    step();
    check("dual_even_valid", even_valid, 1);
    check("dual_odd_valid", odd_valid, 1);
    check("dual_even_slot", even_slot, 0);
    check("dual_odd_slot", odd_slot, 1);
    check("dual_cnt_1", dual_cnt, 1);
    check("dual_split_0", split_cnt, 0);
    repeat (3) step();

    // both slots even: split, slot2 follows on the even pipe
    push(32'hA000_0002, 32'hB000_0002, 1, 1, 1, 1, 7'd1, 7'd2, 1, 1, 21'd0, 3'b000);
    step();
    check("same_k1_even_instr", {even_valid, even_slot, even_instr}, {2'b10, 32'hA000_0002});
    check("same_k1_odd_valid", odd_valid, 0);
    step();
    check("same_k2_even_instr", {even_valid, even_slot, even_instr}, {2'b11, 32'hB000_0002});
    check("same_k2_odd_valid", odd_valid, 0);
    check("same_split_cnt", split_cnt, 1);
    repeat (3) step();

    // RAW through ra forces a split
    push(32'hA000_0003, 32'hB000_0003, 1, 1, 1, 0, 7'd5, 7'd6, 1, 1,
         {7'd5, 7'd0, 7'd0}, 3'b001);
    step();
    check("raw_k1", {even_valid, odd_valid}, 2'b10);
    step();
    check("raw_k2_odd", {odd_valid, odd_slot, odd_instr}, {2'b11, 32'hB000_0003});
    check("raw_split_cnt", split_cnt, 2);
    repeat (3) step();

    // same registers but ra disabled: dual issue
    push(32'hA000_0004, 32'hB000_0004, 1, 1, 1, 0, 7'd5, 7'd6, 1, 1,
         {7'd5, 7'd0, 7'd0}, 3'b000);
    step();
    check("noraw_k1", {even_valid, odd_valid}, 2'b11);
    check("noraw_dual_cnt", dual_cnt, 2);
    repeat (3) step();

    // WAW on r9 forces a split
    push(32'hA000_0005, 32'hB000_0005, 1, 1, 1, 0, 7'd9, 7'd9, 1, 1, 21'd0, 3'b000);
    step();
    check("waw_k1", {even_valid, odd_valid}, 2'b10);
    step();
    check("waw_k2", {even_valid, odd_valid}, 2'b01);
    check("waw_split_cnt", split_cnt, 3);
    repeat (3) step();

    // slot2 invalid: single issue, no counter change
    push(32'hA000_0006, 32'hB000_0006, 1, 0, 1, 0, 7'd1, 7'd2, 1, 1, 21'd0, 3'b000);
    step();
    check("v2off_even", {even_valid, even_slot, even_instr}, {2'b10, 32'hA000_0006});
    check("v2off_odd_valid", odd_valid, 0);
    step();
    check("v2off_cnts", {dual_cnt, split_cnt}, {16'd2, 16'd3});
    repeat (3) step();

    // both slots invalid: pops with no output
    push(32'hA000_0007, 32'hB000_0007, 0, 0, 1, 0, 7'd1, 7'd2, 1, 1, 21'd0, 3'b000);
    step();
    check("blank_outputs", {even_valid, odd_valid}, 2'b00);
    step();
    check("blank_cnts", {dual_cnt, split_cnt}, {16'd2, 16'd3});

    // even pipe stalled 8 cycles while 6 independent pairs are pushed
    even_ready = 1'b0;
    fork
      begin
        for (int n = 0; n < 6; n++)
          push(32'hC000_0000 + 32'(n), 32'hD000_0000 + 32'(n), 1, 1, 1, 0,
               7'(20 + n), 7'(40 + n), 1, 1, 21'd0, 3'b000);
      end
      begin
        for (int c = 0; c < 8; c++) begin
          step();
          if (c == 3) check("bp_in_ready_3", in_ready, 1);
          if (c == 4) check("bp_in_ready_full", in_ready, 0);
          if (c == 5) check("bp_even_held", {even_valid, even_instr}, {1'b1, 32'hC000_0000});
        end
        even_ready = 1'b1;
      end
    join
    wait_drain();
    check("bp_dual_cnt", dual_cnt, 8);
    check("bp_split_cnt", split_cnt, 3);
    repeat (2) step();

    // flush while slot2 pending, with a simultaneous push
    push(32'hE000_0001, 32'hE000_0002, 1, 1, 1, 1, 7'd1, 7'd2, 1, 1, 21'd0, 3'b000);
    step();
    check("fl_slot1_issued", {even_valid, even_slot, even_instr}, {2'b10, 32'hE000_0001});
    set_fields(32'hF000_0001, 32'hF000_0002, 1, 1, 1, 0, 7'd1, 7'd2, 1, 1, 21'd0, 3'b000);
    in_valid = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    exp_even.delete();
    exp_odd.delete();
    check("fl_outputs", {even_valid, odd_valid}, 2'b00);
    check("fl_in_ready", in_ready, 1);
    check("fl_split_kept", split_cnt, 3);
    check("fl_dual_kept", dual_cnt, 8);
    repeat (2) step();
    check("fl_nothing_issued", {even_valid, odd_valid}, 2'b00);

    // reset mid-stream clears outputs and counters immediately
    push(32'hA000_0008, 32'hB000_0008, 1, 1, 1, 0, 7'd1, 7'd2, 1, 1, 21'd0, 3'b000);
    step();
    check("rs_before", {even_valid, odd_valid}, 2'b11);
    #2 reset = 1'b0;
    #1;
    exp_even.delete();
    exp_odd.delete();
    check("rs_outputs", {even_valid, odd_valid, even_instr}, {2'b00, 32'h0});
    check("rs_counters", {dual_cnt, split_cnt}, 32'h0);
    check("rs_in_ready", in_ready, 1);
    @(negedge clk);
    reset = 1'b1;
    step();
    push(32'hA000_0009, 32'hB000_0009, 1, 1, 1, 0, 7'd1, 7'd2, 1, 1, 21'd0, 3'b000);
    step();
    check("rs_recover_dual", dual_cnt, 1);
    wait_drain();

    // DUAL_EN=0 instance: legal even/odd pair is split
    check("d0_in_ready", d0_in_ready, 1);
    set_fields(32'hA000_000A, 32'hB000_000A, 1, 1, 1, 0, 7'd1, 7'd2, 1, 1, 21'd0, 3'b000);
    d0_in_valid = 1'b1;
    step();
    d0_in_valid = 1'b0;
    step();
    check("d0_k1", {d0_even_valid, d0_even_slot, d0_even_instr, d0_odd_valid},
          {2'b10, 32'hA000_000A, 1'b0});
    step();
    check("d0_k2", {d0_odd_valid, d0_odd_slot, d0_odd_instr}, {2'b11, 32'hB000_000A});
    check("d0_cnts", {d0_dual_cnt, d0_split_cnt}, {16'd0, 16'd1});

    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spu_dual_issue_router.md
Name: spu_dual_issue_router

Overview:
Parametrised issue stage that sits after the SPU instruction decoder. It buffers decoded instruction pairs in a FIFO and routes each slot to the even or odd pipe through registered valid/ready outputs. Pairs issue in order. A pair is dual-issued only when its two slots target different pipes and have no intra-pair hazard; otherwise it is split over two or more cycles. Issue statistics are kept in counters.

Parameters:
INSTR_W, 32, instruction word width
REG_AW, 7, register-address width (128 registers)
PAIR_DEPTH, 4, pair FIFO depth; power of 2, >=2
DUAL_EN, 1, 0 forces single issue (every valid pair is split)
CNT_W, 16, statistics counter width; counters saturate

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
flush  in  1  synchronous flush of FIFO, pending slots and outputs
in_valid  in  1  decoded pair present
in_ready  out  1  FIFO not full
in_instr1, in_instr2  in  INSTR_W each  slot1 (older), slot2
in_v1, in_v2  in  1 each  slot holds a real instruction
in_even1, in_even2  in  1 each  1 = even pipe, 0 = odd pipe
in_dst1, in_dst2  in  REG_AW each  destination register
in_dst_en1, in_dst_en2  in  1 each  destination is written
in_src2  in  3*REG_AW  slot2 ra, rb, rc, packed MSB-first
in_src_en2  in  3  per-source valid, [0]=ra
even_valid, odd_valid  out  1 each  output register holds an instruction
even_ready, odd_ready  in  1 each  pipe accepts
even_instr, odd_instr  out  INSTR_W each  issued word
even_slot, odd_slot  out  1 each  0 = came from slot1, 1 = from slot2
dual_cnt, split_cnt  out  CNT_W each  statistics

Behaviour:
- Reset (reset=0, asynchronous): FIFO empty, both pending bits cleared, all *_valid=0, *_instr=0, *_slot=0, counters=0, in_ready=1.
- Push: on in_valid && in_ready. in_ready = !full, registered count based; a push into a full FIFO is not possible, and push with pop while full is not allowed.
- Head pair: pend1 = in_v1, pend2 = in_v2 are loaded when the pair becomes head. An invalid slot counts as already issued. A pair with both slots invalid pops in 1 cycle with no output and no counter change.
- Pipe P is free when !P_valid || P_ready. An accepted output clears P_valid unless it is reloaded in the same cycle.
- Slot1 issues when pend1 and its pipe is free.
- Slot2 issues when pend2, its pipe is free, and one of:
  - (a) pend1 is already 0 from an earlier cycle; or
  - (b) slot1 issues this cycle, and DUAL_EN=1, and in_even2 != in_even1, and no RAW (no enabled src2 equals in_dst1 while in_dst_en1), and no WAW (dst_en1 && dst_en2 && dst1==dst2).
- Slot2 never issues before slot1.
- Issue = load the pipe output register on the next edge. Latency: a pair pushed at edge k issues at edge k+1 at the earliest.
- Head pops when its last pending slot issues. The next pair becomes head the following cycle (no issue overlap across pairs; strict in-order).
- Counters, for pairs with both slots valid only:
  - dual_cnt increments when both slots issue in the same cycle.
  - split_cnt increments when slot2 issues in a later cycle.
  - Both saturate at 2^CNT_W-1.
- Outputs hold stable while valid && !ready.
- flush: at the next edge FIFO is empty, pend bits are cleared and *_valid=0. Flush overrides a simultaneous push and any issue. Counters are kept.
- Reset mid-operation: immediate clear, as on reset; the in-flight pair is lost.

Test Plan:
- Pair {even add, odd load}, no deps, both ready=1 -> edge k+1: even_valid=odd_valid=1, even_slot=0, odd_slot=1; dual_cnt=1.
- Both slots even -> slot1 on even at k+1, slot2 on even at k+2 (even_slot=1); split_cnt=1, odd_valid stays 0.
- Slot1 even dst=5 en; slot2 odd with ra=5 en -> RAW forces split (k+1, k+2). Repeat with the ra enable cleared -> dual issue.
- even_ready=0 for 8 cycles while pushing 6 pairs -> in_ready drops after 4 are buffered; even_instr is held constant; on release all pairs drain in order and no word is lost.
- Flush asserted the cycle slot2 is pending, with in_valid=1 -> next cycle FIFO is empty, outputs invalid, the pushed pair is dropped. Reset asserted mid-stream -> outputs and counters read 0 immediately.
- DUAL_EN=0 with a legal even/odd pair -> split over 2 cycles. Pair with in_v2=0 -> single issue, no counter change.
